// File: rtl/uart_rx_fsm_param_if.sv
// Receive-side bus of the UART receiver.
// The serial line and read strobe go in; the framed word and its status come out.
interface uart_rx_fsm_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_in;
  logic                 data_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 parity_error;
  logic                 framing_error;
  logic                 overrun_error;
  logic                 busy;

  modport master (
    output serial_in,
    output data_read,
    input  rx_data,
    input  data_ready,
    input  parity_error,
    input  framing_error,
    input  overrun_error,
    input  busy
  );

  modport slave (
    input  serial_in,
    input  data_read,
    output rx_data,
    output data_ready,
    output parity_error,
    output framing_error,
    output overrun_error,
    output busy
  );
endinterface

// File: rtl/uart_rx_fsm_param.sv
// UART receive controller: bit timer, bit counter, shift register,
// parity and stop checks, and the output buffer in one FSM.
module uart_rx_fsm_param #(
  parameter int CLKS_PER_BIT = 10,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic               clk,
  input  logic               n_rst,
  uart_rx_fsm_param_if.slave bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FULL_M1 = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic PAR_ON  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_STORE
  } state_t;

  state_t               r_state;
  state_t               w_state;
  logic [TW-1:0]        r_timer;
  logic [TW-1:0]        w_timer;
  logic [3:0]           r_bitcnt;
  logic [3:0]           w_bitcnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift;
  logic                 r_par;
  logic                 w_par;
  logic                 r_fe;
  logic                 w_fe;
  logic                 r_prev;

  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_data_ready;
  logic                 r_parity_error;
  logic                 r_framing_error;
  logic                 r_overrun_error;

  logic w_half;
  logic w_full;
  logic w_store;
  logic w_take;
  logic w_par_err;

  assign w_half    = (r_timer == HALF_M1);
  assign w_full    = (r_timer == FULL_M1);
  assign w_store   = (r_state == S_STORE);
  assign w_take    = bus.data_read & r_data_ready;
  assign w_par_err = PAR_ON & (r_par != PAR_ODD);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_par    <= 1'b0;
      r_fe     <= 1'b0;
      r_prev   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_timer  <= w_timer;
      r_bitcnt <= w_bitcnt;
      r_shift  <= w_shift;
      r_par    <= w_par;
      r_fe     <= w_fe;
      r_prev   <= bus.serial_in;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_timer  = r_timer;
    w_bitcnt = r_bitcnt;
    w_shift  = r_shift;
    w_par    = r_par;
    w_fe     = r_fe;
    unique case (r_state)
      S_IDLE: begin
        if (r_prev && !bus.serial_in) begin
          w_state = S_START;
          w_timer = '0;
        end
      end
      S_START: begin
        if (w_half) begin
          w_timer  = '0;
          w_bitcnt = '0;
          w_par    = 1'b0;
          w_fe     = 1'b0;
          w_state  = bus.serial_in ? S_IDLE : S_DATA;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_DATA: begin
        if (w_full) begin
          w_timer = '0;
          w_shift = {bus.serial_in, r_shift[DATA_BITS-1:1]};
          w_par   = r_par ^ bus.serial_in;
          if (r_bitcnt == LAST_DATA) begin
            w_bitcnt = '0;
            w_state  = PAR_ON ? S_PARITY : S_STOP;
          end else begin
            w_bitcnt = r_bitcnt + 4'd1;
          end
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_PARITY: begin
        if (w_full) begin
          w_timer = '0;
          w_par   = r_par ^ bus.serial_in;
          w_state = S_STOP;
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_STOP: begin
        // every stop bit is sampled even after a bad one
        if (w_full) begin
          w_timer = '0;
          if (!bus.serial_in) w_fe = 1'b1;
          if (r_bitcnt == LAST_STOP) begin
            w_bitcnt = '0;
            w_state  = S_STORE;
          end else begin
            w_bitcnt = r_bitcnt + 4'd1;
          end
        end else begin
          w_timer = r_timer + TW'(1);
        end
      end
      S_STORE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rx_data       <= '0;
      r_data_ready    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun_error <= 1'b0;
    end else if (w_store) begin
      r_framing_error <= r_fe;
      if (!r_fe) begin
        r_rx_data      <= r_shift;
        r_parity_error <= w_par_err;
        r_data_ready   <= 1'b1;
        if (r_data_ready && !bus.data_read) r_overrun_error <= 1'b1;
      end else if (w_take) begin
        r_data_ready   <= 1'b0;
        r_parity_error <= 1'b0;
      end
    end else if (w_take) begin
      r_data_ready    <= 1'b0;
      r_parity_error  <= 1'b0;
      r_framing_error <= 1'b0;
    end
  end

  assign bus.rx_data       = r_rx_data;
  assign bus.data_ready    = r_data_ready;
  assign bus.parity_error  = r_parity_error;
  assign bus.framing_error = r_framing_error;
  assign bus.overrun_error = r_overrun_error;
  assign bus.busy          = (r_state != S_IDLE);

endmodule

// File: doc/uart_rx_fsm_param.md
# uart_rx_fsm_param

Parametrised UART receive controller: next generation of the receiver control unit, with bit timer, bit counter, shift register, parity check, multi-stop-bit check and output buffer merged into one block. It takes an already-synchronised serial line and delivers framed data words with status flags to the consumer over a ready/read handshake. It sits between the input synchroniser and the receive FIFO/bus interface of the UART.

## Interface
- CLKS_PER_BIT, default 10: clocks per serial bit; legal range 4..1023, even values only.
- DATA_BITS, default 8: data bits per frame; legal range 5..9.
- PARITY_EN, default 0: 1 = a parity bit follows the data bits.
- PARITY_ODD, default 0: 1 = odd parity, 0 = even. Ignored when PARITY_EN = 0.
- STOP_BITS, default 1: number of stop bits, 1 or 2.
- clk  in  1  system clock; all state changes on rising edge.
- n_rst  in  1  asynchronous, active-low reset.
- serial_in  in  1  synchronised serial line; idle high.
- data_read  in  1  consumer has taken rx_data; single-cycle pulse.
- rx_data  out  DATA_BITS  last received word; LSB = first data bit on the line.
- data_ready  out  1  rx_data holds an unread word.
- parity_error  out  1  parity mismatch on the word in rx_data.
- framing_error  out  1  last frame had a 0 in a stop-bit position.
- overrun_error  out  1  sticky: an unread word was overwritten.
- busy  out  1  a frame is in progress (state other than IDLE).

## Operation
- States: IDLE, START, DATA, PARITY, STOP, STORE.
- A registered copy of serial_in (prev) is kept in every state. Its reset value is 0, so a line held low through reset does not start a frame.
- IDLE: if prev = 1 and serial_in = 0 (falling edge), go to START and clear the bit timer.
- START: sample serial_in CLKS_PER_BIT/2 clocks after the edge cycle.
  - Sample = 1: false start; return to IDLE, no flag changes.
  - Sample = 0: go to DATA.
- DATA: sample every CLKS_PER_BIT clocks and shift the bit into the shift register LSB-first. After DATA_BITS samples, go to PARITY if PARITY_EN, else STOP.
- PARITY: one sample. Error if XOR(data bits, parity bit) != PARITY_ODD.
- STOP: STOP_BITS samples, CLKS_PER_BIT apart. Any sample = 0 marks a framing error. All stop bits are still sampled before leaving STOP.
- STORE: lasts exactly one cycle, then IDLE.
  - framing_error is set to the frame's framing result.
  - If there is no framing error:
    - rx_data is loaded from the shift register.
    - parity_error is loaded from the frame's parity result (0 when PARITY_EN = 0).
    - data_ready is set to 1.
    - If data_ready was already 1 and data_read is not asserted in this cycle, overrun_error is set to 1.
  - If there is a framing error: rx_data, data_ready and parity_error are unchanged.
- data_read:
  - Clears data_ready and parity_error on the next edge.
  - Does not clear overrun_error.
  - Clears framing_error on the next edge.
  - data_read while data_ready = 0 is ignored.
- overrun_error clears only on reset.
- The shift register is DATA_BITS wide. The parity XOR covers exactly DATA_BITS + 1 bits.

## Timing
- Reset values: rx_data = 0, data_ready = 0, parity_error = 0, framing_error = 0, overrun_error = 0, busy = 0, state = IDLE, timer = 0, bit count = 0.
- Edge cycle = the cycle in which IDLE sees the falling edge. busy = 1 from the next edge.
- Start sample: edge cycle + CLKS_PER_BIT/2. Each later sample: previous sample + CLKS_PER_BIT.
- Final stop sample edge E:
  - the state enters STORE at E;
  - outputs update and busy drops at E+1.
- Total latency, edge cycle to data_ready: CLKS_PER_BIT/2 + (DATA_BITS + PARITY_EN + STOP_BITS) × CLKS_PER_BIT + 1 clocks.
- A new falling edge is accepted in the first IDLE cycle after STORE, so back-to-back frames are supported.
- A falling edge on serial_in during a frame (not IDLE) is ignored except as sampled data.
- Asserting n_rst mid-frame forces all reset values immediately; the partial frame is discarded.
- data_read in the same cycle as STORE with data_ready = 1: no overrun, and data_ready stays 1 with the new word.

## Test plan
- Defaults, frame 0x5A (start 0, bits 0,1,0,1,1,0,1,0, stop 1) → data_ready rises 96 clocks after the edge cycle; rx_data = 0x5A; all errors 0.
- PARITY_EN = 1, PARITY_ODD = 0, frame 0xA5 sent with parity bit 1 → rx_data = 0xA5, parity_error = 1. Repeat with parity bit 0 → parity_error = 0.
- STOP_BITS = 2, second stop bit driven 0 → framing_error = 1; data_ready and rx_data unchanged from the previous frame.
- 0x11 received and not read, then 0x22 received → rx_data = 0x22, overrun_error = 1. overrun_error stays 1 after data_read; data_ready = 0.
- Low glitch of 3 clocks in IDLE → busy pulses, returns to IDLE; no output change.
- n_rst pulsed at the fourth data bit, then a clean 0x33 frame → all outputs 0 after reset; next frame gives rx_data = 0x33 with no errors.
